// File: rtl/tricam_line_scheduler_pkg.sv
// Shared state encoding, default parameters and sizing helpers for the tri-camera line scheduler.
package tricam_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_WAIT_LINE = 3'd2,
    S_READ      = 3'd3,
    S_GAP       = 3'd4,
    S_ABORT     = 3'd5
  } state_e;

  localparam int LINE_N_DEF   = 505;
  localparam int PIXEL_N_DEF  = 708;
  localparam int GAP_N_DEF    = 16;
  localparam int SKEW_TMO_DEF = 4096;
  localparam int FLUSH_N_DEF  = 8;
  localparam int CNT_W_DEF    = 11;
  localparam int LINE_IDX_W   = 10;

  // Width of a counter that runs 0 .. limit-1, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tricam_line_scheduler_if.sv
// FIFO-side and Camera Link-side signals around the scheduler; the scheduler is the master.
interface tricam_line_scheduler_if #(
  parameter int CNT_W = tricam_pkg::CNT_W_DEF
);
  import tricam_pkg::*;

  logic                  I_en;
  logic                  I_frame_start;
  logic                  I_err_clr;
  logic [CNT_W-1:0]      I_C1_rd_cnt;
  logic [CNT_W-1:0]      I_C2_rd_cnt;
  logic [CNT_W-1:0]      I_C3_rd_cnt;
  logic                  O_fifo_rden;
  logic                  O_fifo_rst;
  logic                  O_CM_Fval;
  logic                  O_CM_Lval;
  logic                  O_CM_Dval;
  logic [LINE_IDX_W-1:0] O_line_idx;
  logic                  O_skew_err;
  logic                  O_busy;

  modport master (
    input  I_en, I_frame_start, I_err_clr, I_C1_rd_cnt, I_C2_rd_cnt, I_C3_rd_cnt,
    output O_fifo_rden, O_fifo_rst, O_CM_Fval, O_CM_Lval, O_CM_Dval,
           O_line_idx, O_skew_err, O_busy
  );

  modport slave (
    output I_en, I_frame_start, I_err_clr, I_C1_rd_cnt, I_C2_rd_cnt, I_C3_rd_cnt,
    input  O_fifo_rden, O_fifo_rst, O_CM_Fval, O_CM_Lval, O_CM_Dval,
           O_line_idx, O_skew_err, O_busy
  );

endinterface

// File: rtl/tricam_line_scheduler_cl_timing_gen.sv
// Registers the Camera Link valids: Lval/Dval follow the FIFO read enable by one cycle
// (read latency of the non-FWFT FIFOs), Fval is a set/clear flag steered by the scheduler.
module cl_timing_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic rden,
  input  logic fval_set,
  input  logic fval_clr,
  output logic fval,
  output logic lval,
  output logic dval
);

  logic fval_q, fval_d;
  logic lval_q, lval_d;
  logic dval_q, dval_d;

  // Next-value logic: clear has priority so the frame can always be closed.
  always_comb begin
    fval_d = fval_q;
    if (fval_set) fval_d = 1'b1;
    if (fval_clr) fval_d = 1'b0;
    lval_d = rden;
    dval_d = rden;
  end

  // Valid registers, dropped by reset on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      dval_q <= 1'b0;
    end else begin
      fval_q <= fval_d;
      lval_q <= lval_d;
      dval_q <= dval_d;
    end
  end

  assign fval = fval_q;
  assign lval = lval_q;
  assign dval = dval_q;

endmodule

// File: rtl/tricam_line_scheduler.sv
// Tri-camera line scheduler: waits until all three channel FIFOs hold a full line, then bursts
// one line out of them in lockstep, and aborts the frame if the channels drift apart too long.
module tricam_line_scheduler
  import tricam_pkg::*;
#(
  parameter int LINE_N   = LINE_N_DEF,
  parameter int PIXEL_N  = PIXEL_N_DEF,
  parameter int GAP_N    = GAP_N_DEF,
  parameter int SKEW_TMO = SKEW_TMO_DEF,
  parameter int FLUSH_N  = FLUSH_N_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                     I_CM_Clk,
  input logic                     I_rstn,
  tricam_line_scheduler_if.master bus
);

  localparam int PHASE_W = cnt_w(max3(FLUSH_N, PIXEL_N, GAP_N));
  localparam int SKEW_W  = cnt_w(SKEW_TMO);
  localparam int LINE_W  = cnt_w(LINE_N);

  localparam logic [PHASE_W-1:0] FLUSH_LAST = PHASE_W'(FLUSH_N - 1);
  localparam logic [PHASE_W-1:0] READ_LAST  = PHASE_W'(PIXEL_N - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(GAP_N - 1);
  localparam logic [SKEW_W-1:0]  SKEW_LAST  = SKEW_W'(SKEW_TMO - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(LINE_N - 1);
  localparam logic [CNT_W-1:0]   PIX_THR    = CNT_W'(PIXEL_N);

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  cnt_q, cnt_d;
  logic [SKEW_W-1:0]   skew_q, skew_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                err_q, err_d;
  logic                in_reset_q, in_reset_d;
  logic                fval_set, fval_clr;
  logic                c1_full, c2_full, c3_full, all_full, any_full;

  assign c1_full  = (bus.I_C1_rd_cnt >= PIX_THR);
  assign c2_full  = (bus.I_C2_rd_cnt >= PIX_THR);
  assign c3_full  = (bus.I_C3_rd_cnt >= PIX_THR);
  assign all_full = c1_full & c2_full & c3_full;
  assign any_full = c1_full | c2_full | c3_full;

  // Next-state, phase/skew/line counters, sticky error and Fval steering.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    skew_d     = '0;
    line_d     = line_q;
    err_d      = err_q;
    in_reset_d = 1'b0;
    fval_set   = 1'b0;
    fval_clr   = 1'b0;
    if (bus.I_err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.I_frame_start && bus.I_en) begin
          state_d = S_FLUSH;
          line_d  = '0;
        end
      end
      S_FLUSH: begin
        line_d = '0;
        if (cnt_q == FLUSH_LAST) state_d = S_WAIT_LINE;
        else                     cnt_d   = cnt_q + PHASE_W'(1);
      end
      S_WAIT_LINE: begin
        if (all_full) begin
          state_d = S_READ;
          if (line_q == '0) fval_set = 1'b1;
        end else if (any_full) begin
          if (skew_q == SKEW_LAST) begin
            state_d  = S_ABORT;
            err_d    = 1'b1;
            fval_clr = 1'b1;
          end else begin
            skew_d = skew_q + SKEW_W'(1);
          end
        end
      end
      S_READ: begin
        if (cnt_q == READ_LAST) state_d = S_GAP;
        else                    cnt_d   = cnt_q + PHASE_W'(1);
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (line_q == LINE_LAST) begin
            state_d  = S_IDLE;
            fval_clr = 1'b1;
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = S_WAIT_LINE;
          end
        end else begin
          cnt_d = cnt_q + PHASE_W'(1);
        end
      end
      S_ABORT: begin
        if (cnt_q == FLUSH_LAST) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + PHASE_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset parks the scheduler idle with the FIFOs held in reset.
  always_ff @(posedge I_CM_Clk) begin
    if (!I_rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      skew_q     <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
      in_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skew_q     <= skew_d;
      line_q     <= line_d;
      err_q      <= err_d;
      in_reset_q <= in_reset_d;
    end
  end

  cl_timing_gen u_cl_timing_gen (
    .clk      (I_CM_Clk),
    .rst_n    (I_rstn),
    .rden     (bus.O_fifo_rden),
    .fval_set (fval_set),
    .fval_clr (fval_clr),
    .fval     (bus.O_CM_Fval),
    .lval     (bus.O_CM_Lval),
    .dval     (bus.O_CM_Dval)
  );

  assign bus.O_fifo_rden = (state_q == S_READ);
  assign bus.O_fifo_rst  = in_reset_q | (state_q == S_FLUSH) | (state_q == S_ABORT);
  assign bus.O_busy      = (state_q != S_IDLE);
  assign bus.O_skew_err  = err_q;
  assign bus.O_line_idx  = LINE_IDX_W'(line_q);

endmodule

// File: tb/tb_tricam_line_scheduler.sv
// Self-checking bench for the tri-camera line scheduler, driven against a timeline model.
module tb_tricam_line_scheduler;

  localparam int LINE_N   = 4;
  localparam int PIXEL_N  = 8;
  localparam int GAP_N    = 6;
  localparam int SKEW_TMO = 32;
  localparam int FLUSH_N  = 8;
  localparam int CNT_W    = 11;
  localparam int NEVER    = 1 << 20;

  logic I_CM_Clk = 1'b0;
  logic I_rstn;

  tricam_line_scheduler_if #(.CNT_W(CNT_W)) bus ();

  tricam_line_scheduler #(
    .LINE_N(LINE_N), .PIXEL_N(PIXEL_N), .GAP_N(GAP_N),
    .SKEW_TMO(SKEW_TMO), .FLUSH_N(FLUSH_N), .CNT_W(CNT_W)
  ) dut (
    .I_CM_Clk (I_CM_Clk),
    .I_rstn   (I_rstn),
    .bus      (bus)
  );

  always #5 I_CM_Clk = ~I_CM_Clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  int w_t [LINE_N];
  int r_t [LINE_N];
  int dd  [LINE_N][3];
  int last_l;
  int ab_l;
  int abort_t;
  int end_t;
  bit exp_err;

  task automatic tick();
    @(posedge I_CM_Clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rstn, input bit en, input bit fs, input bit clr,
                               input logic [CNT_W-1:0] c1, input logic [CNT_W-1:0] c2,
                               input logic [CNT_W-1:0] c3);
    I_rstn            = rstn;
    bus.I_en          = en;
    bus.I_frame_start = fs;
    bus.I_err_clr     = clr;
    bus.I_C1_rd_cnt   = c1;
    bus.I_C2_rd_cnt   = c2;
    bus.I_C3_rd_cnt   = c3;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // A read burst of a completed line covers cycles r_t .. r_t+PIXEL_N-1.
  function automatic bit expRden(input int t);
    for (int l = 0; l <= last_l; l++)
      if (l != ab_l && t >= r_t[l] && t < r_t[l] + PIXEL_N) return 1'b1;
    return 1'b0;
  endfunction

  // A channel holds a full line from its arrival until the burst (or abort) takes over.
  function automatic bit chanReady(input int c, input int t);
    int stop;
    for (int l = 0; l <= last_l; l++) begin
      stop = (l == ab_l) ? abort_t : r_t[l];
      if (t >= w_t[l] + dd[l][c] && t < stop) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int expLine(input int t);
    int n = 0;
    for (int l = 1; l <= last_l; l++)
      if (w_t[l] <= t) n++;
    return n;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rden"},     32'(bus.O_fifo_rden), 0);
    checkOutput({tag, " lval"},     32'(bus.O_CM_Lval),   0);
    checkOutput({tag, " dval"},     32'(bus.O_CM_Dval),   0);
    checkOutput({tag, " fval"},     32'(bus.O_CM_Fval),   0);
    checkOutput({tag, " busy"},     32'(bus.O_busy),      0);
    checkOutput({tag, " skew_err"}, 32'(bus.O_skew_err),  0);
    checkOutput({tag, " line_idx"}, 32'(bus.O_line_idx),  0);
    checkOutput({tag, " fifo_rst"}, 32'(bus.O_fifo_rst),  1);
  endtask

  // One frame from an idle cycle: abort_line>=0 starves channel 3 on that line,
  // late_line>=0 makes channel 3 arrive one cycle before the skew limit, rst_mid resets in the 4th read.
  task automatic runFrame(input int abort_line, input int late_line, input bit rst_mid);
    int rst_at, mx, mn, t_fval_end;
    bit fs, en, clr, ef;
    logic [CNT_W-1:0] cv [3];
    ab_l   = abort_line;
    last_l = (abort_line >= 0) ? abort_line : LINE_N - 1;
    for (int l = 0; l <= last_l; l++) begin
      w_t[l] = (l == 0) ? FLUSH_N + 1 : r_t[l-1] + PIXEL_N + GAP_N;
      for (int c = 0; c < 3; c++) dd[l][c] = int'($urandom_range(0, 12));
      if (l == late_line) begin
        dd[l][0] = 0; dd[l][1] = 0; dd[l][2] = SKEW_TMO - 1;
      end
      if (l == abort_line) begin
        dd[l][0] = int'($urandom_range(0, 6));
        dd[l][1] = int'($urandom_range(0, 6));
        dd[l][2] = NEVER;
      end
      mx = (dd[l][0] > dd[l][1]) ? dd[l][0] : dd[l][1];
      mx = (mx > dd[l][2]) ? mx : dd[l][2];
      r_t[l] = w_t[l] + mx + 1;
    end
    if (abort_line >= 0) begin
      mn      = (dd[last_l][0] < dd[last_l][1]) ? dd[last_l][0] : dd[last_l][1];
      abort_t = w_t[last_l] + mn + SKEW_TMO;
      end_t   = abort_t + FLUSH_N;
    end else begin
      abort_t = NEVER;
      end_t   = r_t[last_l] + PIXEL_N + GAP_N;
    end
    t_fval_end = (abort_line >= 0) ? abort_t : end_t;
    rst_at     = rst_mid ? r_t[0] + 3 : NEVER;

    checkOutput("idle busy", 32'(bus.O_busy), 0);
    checkOutput("idle fifo_rst", 32'(bus.O_fifo_rst), 0);

    for (int t = 0; t <= end_t; t++) begin
      if (t >= 1) begin
        if (t == rst_at + 1) begin
          checkResetValues("midread reset");
          exp_err = 1'b0;
          applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
          tick();
          return;
        end
        ef = (abort_line != 0) && t >= r_t[0] && t < t_fval_end;
        checkOutput($sformatf("rden t=%0d", t),     32'(bus.O_fifo_rden), 32'(expRden(t)));
        checkOutput($sformatf("lval t=%0d", t),     32'(bus.O_CM_Lval),   32'(expRden(t - 1)));
        checkOutput($sformatf("dval t=%0d", t),     32'(bus.O_CM_Dval),   32'(expRden(t - 1)));
        checkOutput($sformatf("fval t=%0d", t),     32'(bus.O_CM_Fval),   32'(ef));
        checkOutput($sformatf("busy t=%0d", t),     32'(bus.O_busy),      32'(t < end_t));
        checkOutput($sformatf("fifo_rst t=%0d", t), 32'(bus.O_fifo_rst),
                    32'((t <= FLUSH_N) || (t >= abort_t && t < abort_t + FLUSH_N)));
        checkOutput($sformatf("line_idx t=%0d", t), 32'(bus.O_line_idx),  32'(expLine(t)));
        checkOutput($sformatf("skew_err t=%0d", t), 32'(bus.O_skew_err),  32'(exp_err));
      end
      for (int c = 0; c < 3; c++) begin
        if (chanReady(c, t))
          cv[c] = CNT_W'(PIXEL_N + int'($urandom_range(0, 5)));
        else if (abort_line >= 0 && c == 2 && t >= w_t[last_l])
          cv[c] = CNT_W'(PIXEL_N - 1);
        else
          cv[c] = CNT_W'($urandom_range(0, PIXEL_N - 1));
      end
      fs  = (t == 0) || (t < end_t && (t == r_t[0] + 2 || ($urandom % 5) == 0));
      en  = (t == 0) ? 1'b1 : (t < end_t) ? 1'($urandom % 2) : 1'b0;
      clr = (abort_line >= 0) ? (t == abort_t - 1) : (t < end_t && ($urandom % 8) == 0);
      applyStimulus((t == rst_at) ? 1'b0 : 1'b1, en, fs, clr, cv[0], cv[1], cv[2]);
      if (abort_line >= 0 && t + 1 == abort_t) exp_err = 1'b1;
      else if (clr)                           exp_err = 1'b0;
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    exp_err = 1'b0;
    ab_l    = -1;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    checkResetValues("reset");

    // Release reset: FIFO reset drops once out of reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checkOutput("post reset fifo_rst", 32'(bus.O_fifo_rst), 0);
    checkOutput("post reset busy", 32'(bus.O_busy), 0);

    // Frame start without enable is ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    tick();
    checkOutput("fs no en busy", 32'(bus.O_busy), 0);
    checkOutput("fs no en fifo_rst", 32'(bus.O_fifo_rst), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checkOutput("fs no en busy later", 32'(bus.O_busy), 0);

    // Normal frame with random channel arrival
    runFrame(-1, -1, 1'b0);

    // Channel 3 arrives one cycle before the skew limit
    runFrame(-1, 0, 1'b0);

    // Skew abort on line 0, error clear coinciding with the set
    runFrame(0, -1, 1'b0);
    tick();
    checkOutput("sticky skew_err", 32'(bus.O_skew_err), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    tick();
    checkOutput("cleared skew_err", 32'(bus.O_skew_err), 0);
    exp_err = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Skew abort mid-frame: Fval must drop with the abort
    runFrame(2, -1, 1'b0);

    // Reset during the fourth read cycle, then a clean frame
    runFrame(-1, -1, 1'b1);
    runFrame(-1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/tricam_line_scheduler.md
TRICAM_LINE_SCHEDULER -- requirements
Module: tricam_line_scheduler

Interface
REQ-001 SHALL have parameter LINE_N, default 505, lines per frame.
REQ-002 SHALL have parameter PIXEL_N, default 708, pixels per line (read burst length).
REQ-003 SHALL have parameter GAP_N, default 16, minimum Lval-low cycles between lines.
REQ-004 SHALL have parameter SKEW_TMO, default 4096, maximum cycles one channel may hold a full line before all three do.
REQ-005 SHALL have parameter FLUSH_N, default 8, FIFO reset pulse length in cycles.
REQ-006 SHALL have parameter CNT_W, default 11, FIFO read-count width.
REQ-007 I_CM_Clk  in  1  sole clock; one clock; reset is synchronous and active-low.
REQ-008 I_rstn  in  1  synchronous active-low reset.
REQ-009 I_en  in  1  frame enable; sampled only in S_IDLE.
REQ-010 I_frame_start  in  1  one-cycle pulse, C1 frame-valid rising edge, already in I_CM_Clk domain.
REQ-011 I_C1_rd_cnt / I_C2_rd_cnt / I_C3_rd_cnt  in  CNT_W each  per-channel FIFO read-side word counts, unsigned.
REQ-012 I_err_clr  in  1  clears O_skew_err.
REQ-013 O_fifo_rden  out  1  common read enable to all three FIFOs.
REQ-014 O_fifo_rst  out  1  common FIFO reset.
REQ-015 O_CM_Fval / O_CM_Lval / O_CM_Dval  out  1 each  Camera Link frame, line, data valid.
REQ-016 O_line_idx  out  10  index of current/last line in frame.
REQ-017 O_skew_err  out  1  sticky channel-skew error.
REQ-018 O_busy  out  1  high whenever state is not S_IDLE.

Function
REQ-019 FSM states SHALL be S_IDLE, S_FLUSH, S_WAIT_LINE, S_READ, S_GAP, S_ABORT.
REQ-020 S_IDLE: I_frame_start && I_en -> S_FLUSH; otherwise stay; I_frame_start without I_en ignored.
REQ-021 S_FLUSH: O_fifo_rst high exactly FLUSH_N cycles, line_idx cleared to 0, then -> S_WAIT_LINE.
REQ-022 S_WAIT_LINE: when all three counts >= PIXEL_N in the same cycle -> S_READ next cycle.
REQ-023 S_WAIT_LINE skew timer SHALL count cycles while at least one but not all counts >= PIXEL_N, clear otherwise; reaching SKEW_TMO -> S_ABORT and set O_skew_err.
REQ-024 S_READ: O_fifo_rden high for exactly PIXEL_N consecutive cycles, then -> S_GAP.
REQ-025 O_CM_Lval and O_CM_Dval SHALL equal O_fifo_rden delayed one cycle (FIFO first-word-fall-through off, read latency 1).
REQ-026 S_GAP: stay GAP_N cycles; then if line_idx == LINE_N-1 -> S_IDLE, else line_idx+1 and -> S_WAIT_LINE.
REQ-027 O_CM_Fval SHALL rise in the first S_READ cycle of line 0 (one cycle before O_CM_Lval) and fall in the cycle S_GAP of line LINE_N-1 exits.
REQ-028 S_ABORT: O_fifo_rst high FLUSH_N cycles, O_CM_Fval low, then -> S_IDLE; partial frame discarded.
REQ-029 I_frame_start outside S_IDLE SHALL be ignored.
REQ-030 I_en deassertion mid-frame SHALL not interrupt the frame.
REQ-031 O_skew_err SHALL clear on I_err_clr; simultaneous set and clear: set wins.
REQ-032 Counters SHALL be sized by $clog2 of their limit; count comparisons unsigned, no wrap.

Reset
REQ-033 With I_rstn low at a clock edge: state S_IDLE; O_fifo_rden, O_CM_Fval, O_CM_Lval, O_CM_Dval, O_skew_err, O_busy = 0; O_line_idx = 0; O_fifo_rst = 1 (held while in reset).
REQ-034 Reset asserted mid-READ SHALL drop O_fifo_rden and all valids on the next edge.

Structure
REQ-035 State encoding and default parameter values SHALL live in a shared package tricam_pkg.
REQ-036 A sub-module cl_timing_gen (valid-signal delay/registration for Fval/Lval/Dval) is natural; all else inline.

Verification
REQ-037 Normal frame: LINE_N=4, PIXEL_N=8, counts held 8 -> 4 bursts of 8 rden, Lval = rden+1 cycle, Fval high from first rden to last GAP exit.
REQ-038 Skew: C1, C2 = 8, C3 = 7 for SKEW_TMO=32 cycles -> O_skew_err=1, O_fifo_rst pulse 8 cycles, Fval stays 0, return S_IDLE.
REQ-039 Late channel: C3 reaches 8 at cycle 31 of skew timer -> no error, burst starts next cycle.
REQ-040 I_frame_start pulsed in S_READ and with I_en=0 in S_IDLE -> no state change.
REQ-041 I_rstn low during 4th rden cycle -> next edge rden=0, Lval=0, Fval=0, fifo_rst=1; after release a new frame completes normally.
REQ-042 I_err_clr and skew set in same cycle -> O_skew_err=1.
